// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC owner with redirect priority, memory-wait pending redirect and flush control
module pc_sequencer #(
  parameter int N = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter logic [N-1:0] EXC_VEC = N'(32'h0000_0008),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_jump,
  input  logic [N-1:0]     i_jump_target,
  input  logic             i_branch_taken,
  input  logic [N-1:0]     i_branch_target,
  input  logic             i_exc,
  input  logic             i_eret,
  input  logic [N-1:0]     i_epc,
  input  logic             i_halt,
  input  logic             i_imem_ready,
  output logic [N-1:0]     o_pc,
  output logic             o_fetch_valid,
  output logic             o_flush_if,
  output logic             o_flush_id,
  output logic [CNT_W-1:0] o_stall_cnt
);
  typedef enum logic [1:0] {BOOT, RUN, WAIT, HALT} state_t;
  state_t state;
  logic [N-1:0] pend_pc, tgt, apply_pc;
  logic [2:0] pend_pri, pri;
  logic pend_vld, redir, win, active, apply, to_halt, hold;
  // redirect selection, pending-vs-current arbitration and flush decode
  always_comb begin
    active = state == RUN || state == WAIT;
    redir = i_exc || i_eret || i_branch_taken || i_jump;
    pri = i_exc ? 3'd4 : i_eret ? 3'd3 : i_branch_taken ? 3'd2 : i_jump ? 3'd1 : 3'd0;
    tgt = i_exc ? EXC_VEC : i_eret ? i_epc : i_branch_taken ? i_branch_target : i_jump_target;
    win = redir && (!pend_vld || pri > pend_pri);
    apply_pc = win ? tgt : pend_pc;
    apply = state == RUN ? redir : state == WAIT ? i_imem_ready && (redir || pend_vld) : state == HALT && i_exc;
    to_halt = active && i_halt && !redir && !pend_vld;
    hold = active && !apply && !to_halt && (i_stall || !i_imem_ready);
    o_flush_if = !rst && apply;
    o_flush_id = !rst && ((active && (i_exc || i_eret || i_branch_taken)) || (state == HALT && i_exc));
  end
  // state, PC, pending redirect and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      o_pc <= RESET_PC;
      o_fetch_valid <= 1'b0;
      pend_vld <= 1'b0;
      pend_pc <= RESET_PC;
      pend_pri <= 3'd0;
      o_stall_cnt <= '0;
    end else begin
      if (hold && !(&o_stall_cnt)) o_stall_cnt <= o_stall_cnt + 1'b1;
      if (state == BOOT) begin
        state <= RUN;
        o_fetch_valid <= 1'b1;
      end else if (apply) begin
        o_pc <= apply_pc;
        state <= RUN;
        o_fetch_valid <= 1'b1;
        pend_vld <= 1'b0;
      end else if (to_halt) begin
        state <= HALT;
        o_fetch_valid <= 1'b0;
      end else if (state == WAIT && !i_imem_ready) begin
        if (win) begin
          pend_pc <= tgt;
          pend_pri <= pri;
          pend_vld <= 1'b1;
        end
      end else if (state == RUN && !i_imem_ready) begin
        state <= WAIT;
      end else if (state != HALT) begin
        state <= RUN;
        if (!i_stall) o_pc <= o_pc + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic clk = 0, rst = 1, stall = 0, jump = 0, br = 0, exc = 0, eret = 0, halt = 0, rdy = 1;
  logic [31:0] jt = 0, bt = 0, epc = 0, pc;
  logic fv, fif, fid;
  logic [15:0] cnt;
  logic s_rst = 1, s_stall = 0, s_fv, s_fif, s_fid;
  logic [3:0] s_pc;
  logic [1:0] s_cnt;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  pc_sequencer d (.clk(clk), .rst(rst), .i_stall(stall), .i_jump(jump), .i_jump_target(jt),
    .i_branch_taken(br), .i_branch_target(bt), .i_exc(exc), .i_eret(eret), .i_epc(epc),
    .i_halt(halt), .i_imem_ready(rdy), .o_pc(pc), .o_fetch_valid(fv), .o_flush_if(fif),
    .o_flush_id(fid), .o_stall_cnt(cnt));
  pc_sequencer #(.N(4), .CNT_W(2)) s (.clk(clk), .rst(s_rst), .i_stall(s_stall), .i_jump(1'b0),
    .i_jump_target(4'd0), .i_branch_taken(1'b0), .i_branch_target(4'd0), .i_exc(1'b0),
    .i_eret(1'b0), .i_epc(4'd0), .i_halt(1'b0), .i_imem_ready(1'b1), .o_pc(s_pc),
    .o_fetch_valid(s_fv), .o_flush_if(s_fif), .o_flush_id(s_fid), .o_stall_cnt(s_cnt));
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  initial begin
    step;
    step;
    chk("rst_pc", pc, 0);
    chk("rst_fv", fv, 0);
    chk("rst_fif", fif, 0);
    chk("rst_fid", fid, 0);
    chk("rst_cnt", cnt, 0);
    rst = 0;
    #1;
    chk("boot_fv", fv, 0);
    chk("boot_pc", pc, 0);
    chk("boot_fif", fif, 0);
    for (int i = 0; i < 6; i++) begin
      step;
      chk("seq_pc", pc, i);
      chk("seq_fv", fv, 1);
    end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_fif", fif, 0);
      step;
      chk("stall_pc", pc, 5);
    end
    chk("stall_cnt", cnt, 3);
    stall = 0;
    step;
    chk("post_stall_pc", pc, 6);
    step;
    chk("pc7", pc, 7);
    br = 1; bt = 32'h40; jump = 1; jt = 32'h80; stall = 1;
    #1;
    chk("br_fif", fif, 1);
    chk("br_fid", fid, 1);
    step;
    chk("br_pc", pc, 32'h40);
    br = 0; stall = 0; jt = 10;
    #1;
    chk("jmp_fif", fif, 1);
    chk("jmp_fid", fid, 0);
    step;
    chk("jmp_pc", pc, 10);
    jump = 0; rdy = 0;
    step;
    chk("wait0_pc", pc, 10);
    jump = 1; jt = 32'h20;
    #1;
    chk("wait1_fif", fif, 0);
    step;
    chk("wait1_pc", pc, 10);
    jump = 0; br = 1; bt = 32'h30;
    step;
    chk("wait2_pc", pc, 10);
    br = 0;
    step;
    chk("wait3_pc", pc, 10);
    chk("wait_cnt", cnt, 7);
    rdy = 1;
    #1;
    chk("wready_fif", fif, 1);
    chk("wready_fid", fid, 0);
    step;
    chk("wready_pc", pc, 32'h30);
    jump = 1; jt = 32'h12;
    step;
    chk("pc12", pc, 32'h12);
    jump = 0; halt = 1;
    step;
    chk("halt_fv", fv, 0);
    chk("halt_pc", pc, 32'h12);
    halt = 0; stall = 1;
    step;
    chk("halt2_pc", pc, 32'h12);
    chk("halt2_fv", fv, 0);
    chk("halt_fif", fif, 0);
    chk("halt_cnt", cnt, 7);
    exc = 1;
    #1;
    chk("exc_fif", fif, 1);
    chk("exc_fid", fid, 1);
    step;
    chk("exc_pc", pc, 8);
    chk("exc_fv", fv, 1);
    exc = 0; stall = 0; eret = 1; epc = 32'h13;
    #1;
    chk("eret_fif", fif, 1);
    chk("eret_fid", fid, 1);
    step;
    chk("eret_pc", pc, 32'h13);
    eret = 0;
    step;
    chk("pc14", pc, 32'h14);
    rdy = 0;
    step;
    jump = 1; jt = 32'h50;
    step;
    chk("wpend_pc", pc, 32'h14);
    jump = 0; rst = 1;
    #1;
    chk("rst_mid_fif", fif, 0);
    step;
    chk("rst_mid_pc", pc, 0);
    chk("rst_mid_fv", fv, 0);
    chk("rst_mid_cnt", cnt, 0);
    rst = 0; rdy = 1;
    step;
    chk("reboot_pc", pc, 0);
    step;
    chk("reboot_pc1", pc, 1);
    rdy = 0;
    step;
    rdy = 1;
    #1;
    chk("nopend_fif", fif, 0);
    step;
    chk("nopend_pc", pc, 2);
    s_rst = 0;
    step;
    chk("s_boot_pc", s_pc, 0);
    for (int i = 0; i < 15; i++) step;
    chk("s_pc15", s_pc, 15);
    step;
    chk("s_wrap", s_pc, 0);
    s_stall = 1;
    for (int i = 0; i < 5; i++) step;
    chk("s_sat_cnt", s_cnt, 3);
    chk("s_hold_pc", s_pc, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
